imem_prefetch: RTL
==================

IMEM_PREFETCH -- requirements
Module: imem_prefetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 64, memory depth in words (power of two).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, prefetch queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, default 32'h0, fetch address after reset.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port fetch_en  input  1  permits issuing new memory reads.
REQ-008 SHALL have port load_en  input  1  program-load write strobe.
REQ-009 SHALL have port load_addr  input  $clog2(DEPTH)  word index to write.
REQ-010 SHALL have port load_data  input  DATA_W  word to write.
REQ-011 SHALL have port redirect  input  1  branch/jump: flush and refetch.
REQ-012 SHALL have port redirect_pc  input  32  byte address of new fetch target.
REQ-013 SHALL have port out_valid  output  1  out_instr/out_pc/out_err valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-015 SHALL have port out_instr  output  DATA_W  fetched instruction.
REQ-016 SHALL have port out_pc  output  32  byte address of out_instr.
REQ-017 SHALL have port out_err  output  1  out_pc was outside memory.

Function
REQ-018 SHALL implement storage as DEPTH x DATA_W array with one synchronous read port (1-cycle latency) and one write port.
REQ-019 SHALL index memory by pc[$clog2(DEPTH)+1:2]; pc[1:0] SHALL be ignored.
REQ-020 SHALL issue a read at fetch PC in any cycle where fetch_en=1, redirect=0, load_en=0, and fifo_count + inflight < FIFO_DEPTH.
REQ-021 SHALL advance fetch PC by 4 on each issue; wraps modulo 2^32.
REQ-022 SHALL push {data, pc, err} into the queue the cycle after issue (inflight=1 for exactly that cycle).
REQ-023 SHALL set err=1 and data=all-zero (NOP) when pc >= DEPTH*4.
REQ-024 SHALL drive out_valid = (fifo_count != 0); head fields are stable while out_valid=1 and out_ready=0.
REQ-025 SHALL pop on out_valid && out_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-026 SHALL, on redirect, complete any same-cycle pop, then empty the queue, discard the inflight read, and load fetch PC with {redirect_pc[31:2],2'b00}.
REQ-027 SHALL, after redirect at edge N, issue at edge N+1 and assert out_valid after edge N+2 (given fetch_en=1).
REQ-028 SHALL give load_en priority over issue; a load and a read of the same word in one cycle SHALL return the old word (read-first).
REQ-029 SHALL allow load_en and redirect in the same cycle; both take effect.
REQ-030 SHALL never overflow: queue full with inflight=1 is impossible by REQ-020.
REQ-031 SHALL, with fetch_en=0, stop issuing but still complete the inflight push and continue draining.

Reset
REQ-032 SHALL on reset set fetch PC=RESET_PC, fifo_count=0, inflight=0, out_valid=0, out_instr=0, out_pc=0, out_err=0.
REQ-033 SHALL not clear memory contents on reset; reset mid-fetch SHALL discard inflight data.
REQ-034 SHALL, with fetch_en=1, assert out_valid after the second rising edge following reset deassertion.

Structure
REQ-035 SHALL place default parameter values and the NOP constant (32'h0) in shared package imem_pkg.
REQ-036 SHALL implement the queue as sub-module fetch_fifo (sync FIFO, count output, flush input).

Verification
REQ-037 SHALL check load words 0..3 = 0x20080020,0x20090027,0x01098024,0x01098025, reset, fetch_en=1, out_ready=1 -> outputs in order with out_pc 0,4,8,12, one per cycle after start latency.
REQ-038 SHALL check out_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries held, no issue beyond, head unchanged; release -> no loss/duplication.
REQ-039 SHALL check redirect_pc=0x46 while queue full -> queue flushed, next out_pc=0x44 two edges later, no stale entry.
REQ-040 SHALL check redirect_pc=0x100 (DEPTH=64) -> out_err=1, out_instr=0, out_pc=0x100.
REQ-041 SHALL check load word 5 with 0x1234 in the same cycle as a read of pc 0x14 -> old word returned; refetch returns 0x1234.
REQ-042 SHALL check reset asserted with 3 entries queued and inflight=1 -> out_valid=0 next cycle, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared defaults and constants for the instruction-memory prefetcher.
package imem_pkg;

    localparam int unsigned DefDataW     = 32;
    localparam int unsigned DefDepth     = 64;
    localparam int unsigned DefFifoDepth = 4;
    localparam logic [31:0] DefResetPc   = 32'h0;

    // Instruction substituted for fetches outside the memory.
    localparam logic [31:0] NopInstr = 32'h0;

    // Byte address forced to word alignment.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue with occupancy count and single-cycle flush.
// Push into a full queue is never requested by the fetch logic.
module fetch_fifo #(
    parameter int unsigned WIDTH = 65,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] store_q [DEPTH];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer and count next-state; flush wins over any same-cycle push/pop.
    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents need no reset since count gates validity.
    always_ff @(posedge clk_i) begin
        if (do_push && !rst_i) begin
            store_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = store_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/imem_prefetch.sv
// Instruction memory with a sequential prefetcher feeding a small queue.
// A read issued at one edge is pushed into the queue at the next edge.
module imem_prefetch
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter logic [31:0] RESET_PC   = DefResetPc,
    localparam int unsigned AddrW     = $clog2(DEPTH),
    localparam int unsigned CntW      = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned EntryW    = DATA_W + 33
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              load_en,
    input  logic [AddrW-1:0]  load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [31:0]       out_pc,
    output logic              out_err
);

    localparam logic [32:0] MemBytes = 33'(DEPTH) * 33'd4;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [31:0]       pc_q, pc_d;
    logic              inflight_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [31:0]       rd_pc_q;
    logic              rd_err_q;
    logic              issue;
    logic              issue_err;
    logic              push;
    logic [CntW-1:0]   fifo_count;
    logic [EntryW-1:0] head;

    // Issue decision and fetch PC next-state; a redirect overrides sequential advance.
    always_comb begin
        issue_err = {1'b0, pc_q} >= MemBytes;
        issue     = fetch_en && !redirect && !load_en
                    && ((32'(fifo_count) + 32'(inflight_q)) < FIFO_DEPTH);
        pc_d      = pc_q;
        if (redirect) begin
            pc_d = align_pc(redirect_pc);
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Fetch PC and inflight flag; reset drops any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
        end
    end

    // Program-load write port; nonblocking update gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Synchronous read port; out-of-range fetches return a NOP tagged as error.
    always_ff @(posedge clk) begin
        if (issue) begin
            rd_data_q <= issue_err ? DATA_W'(NopInstr) : mem_q[pc_q[AddrW+1:2]];
            rd_pc_q   <= pc_q;
            rd_err_q  <= issue_err;
        end
    end

    // Inflight data is discarded when a redirect flushes the queue.
    assign push = inflight_q && !redirect;

    fetch_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_i       (reset),
        .flush_i     (redirect),
        .push_i      (push),
        .push_data_i ({rd_data_q, rd_pc_q, rd_err_q}),
        .pop_i       (out_ready),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    // Head fields are forced to zero while the queue is empty.
    always_comb begin
        out_valid = (fifo_count != '0);
        out_instr = '0;
        out_pc    = '0;
        out_err   = 1'b0;
        if (out_valid) begin
            {out_instr, out_pc, out_err} = head;
        end
    end

endmodule
